// File: rtl/bcd2bin_16.sv
// bcd2bin_16: sequential 4-digit BCD to binary converter (reverse double-dabble)
// with start/busy/done handshake and invalid-digit flag.
module bcd2bin_16 #(
   parameter int DIGITS = 4,
   parameter int OUT_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [OUT_W-1:0]      bin_out,
   output logic                  err
);
   localparam int W  = 4*DIGITS + OUT_W;
   localparam int CW = $clog2(OUT_W);
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   state_t           state_q;
   logic [W-1:0]     sr_q, sr_d;
   logic [CW-1:0]    cnt_q;
   logic             inv_q, busy_q, done_q, err_q, bad;
   logic [OUT_W-1:0] bin_q;
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) bad = bad | (bcd_in[4*i +: 4] > 4'd9);
   end
   // correction acts on the already-shifted nibbles within the same cycle
   always_comb begin
      sr_d = sr_q >> 1;
      for (int i = 0; i < DIGITS; i++)
         sr_d[OUT_W+4*i +: 4] = (sr_d[OUT_W+4*i +: 4] >= 4'd8) ? sr_d[OUT_W+4*i +: 4] - 4'd3 : sr_d[OUT_W+4*i +: 4];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         inv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bin_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               inv_q   <= bad;
               sr_q    <= {bcd_in, {OUT_W{1'b0}}};
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= bad ? DONE : CONV;
            end
            CONV: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(OUT_W-1)) state_q <= DONE;
            end
            DONE: begin
               done_q  <= 1'b1;
               err_q   <= inv_q;
               bin_q   <= inv_q ? '0 : sr_q[OUT_W-1:0];
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign busy    = busy_q;
   assign done    = done_q;
   assign bin_out = bin_q;
   assign err     = err_q;
endmodule

// File: doc/bcd2bin_16.md
Name: bcd2bin_16

Overview:
Sequential BCD-to-binary decoder. It is the inverse of the clock display path's binary-to-BCD conversion. It takes four packed BCD digits, for example minutes or seconds keyed in on the board for time-set or preset. It uses reverse double-dabble (shift right, subtract 3) to produce a binary value for loading into the minute/second counters. It has a start/busy/done handshake and flags invalid BCD digits.

Parameters:
DIGITS  4   number of BCD digits; fixed at 4 for this revision (input width 4*DIGITS)
OUT_W   14  binary result width; must satisfy 2^OUT_W > 10^DIGITS-1 (14 covers 9999)

Ports:
clk      input   1   system clock (50 MHz MAX10_CLK1_50 at top level)
rst_n    input   1   asynchronous active-low reset
start    input   1   request conversion; sampled on rising clk edge, honoured only in IDLE
bcd_in   input   16  packed digits: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
busy     output  1   high while a conversion is in progress
done     output  1   single-cycle pulse when bin_out/err are valid
bin_out  output  14  binary result, held until next accepted start
err      output  1   high when the last request contained a digit >9; held with bin_out

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy=0, done=0, bin_out=0, err=0, shift register=0, counter=0. Deassertion takes effect on the next clk edge.
- States: IDLE, CONV, DONE.
- IDLE:
  - On an edge with start=1, capture bcd_in.
  - If any nibble >9: set err=1 and bin_out=0, go to DONE. No CONV cycles.
  - Otherwise: load the 30-bit working register {bcd_in, 14'b0}, set bit counter=0, err=0, go to CONV.
  - start=0: remain in IDLE, outputs unchanged.
- CONV, one iteration per clk:
  - Shift the working register right by 1. The LSB of the BCD field enters the MSB of the binary field.
  - Then, on the shifted value, for each of the 4 BCD nibbles independently: if nibble >=8, subtract 3.
  - The correction is combinational within the same cycle as the shift. It must use the post-shift nibble.
  - The counter increments each cycle. After the 14th iteration (counter reaches 13), go to DONE.
- DONE (one cycle):
  - done=1, bin_out = binary field of the working register (or 0 on err).
  - Return to IDLE on the next edge.
  - done is a registered output, high for exactly one clk.
- busy is high in CONV and DONE and low in IDLE.
- Latency, valid input: start sampled at edge N; CONV occupies edges N+1..N+14; done high during the cycle after edge N+15. Total 15 clocks from start edge to done.
- Latency, invalid input: done and err are high during the cycle after edge N+1.
- Back-to-back: start high in the same cycle done is high is ignored (state is DONE). It is accepted on the following IDLE edge. Minimum repeat interval is 16 clocks.
- start asserted during CONV/DONE: ignored, no queueing. bcd_in changes during CONV do not affect the result (captured at start).
- bin_out and err change only on entry to DONE. Between conversions they hold the last result.
- Reset mid-conversion: abort immediately to IDLE with all outputs 0. No done pulse.
- Range: all valid inputs 0000..9999 give bin_out = 0..9999 exactly. No overflow is possible with OUT_W=14.
- No combinational path from any input to any output.

Test Plan:
- Reset then bcd_in=16'h0000, start 1 clk -> busy 1 for 15 clks; done pulse 15 clks after start edge; bin_out=0, err=0.
- bcd_in=16'h9999, start -> bin_out=14'd9999 (0x270F), err=0, done exactly 1 clk wide.
- Sweep: bcd_in=16'h1234 -> 1234 (0x04D2); 16'h0059 -> 59; 16'h0100 -> 100. Compare against a bench model for all 10000 valid inputs.
- Invalid: bcd_in=16'h12A4, start -> done 1 clk after start edge, err=1, bin_out=0. Next valid request 16'h0007 -> err=0, bin_out=7.
- start held high continuously with 16'h0042 -> one conversion per 16 clks, each giving 42. start pulses during CONV have no effect. Changing bcd_in mid-CONV does not alter the result.
- rst_n low at CONV iteration 7, asynchronously mid-cycle -> busy/done/bin_out/err all 0 immediately. No done pulse. The next start converts correctly.
